seq_step_sched: RTL and testbench
=================================

// Module: seq_step_sched
//
// PURPOSE
//   Step scheduler for the integer-sequence generator bank (squares, 3^n, triangular, Fibonacci,
//   Pell, Lucas, Padovan, Sylvester, shared counter). Issues the step_en advance strobe that every
//   generator and the shared counter qualify their update with. Drives the 3-bit output-mux select.
//   Supports free-run at a programmable rate, pause, N-step bursts, and auto-scan across all sources.
//
// PARAMETERS
//   NUM_SRC  8  number of selectable sequence sources; sel wraps NUM_SRC-1 -> 0
//   SEL_W    3  width of sel; must satisfy 2**SEL_W >= NUM_SRC
//   CNT_W    8  width of cmd_arg, prescaler, burst, dwell and step counters
//
// PORTS
//   clk         in   1      system clock, all state on rising edge
//   reset       in   1      synchronous, active-high; dominates all other inputs
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      scheduler can accept a command this cycle
//   cmd_op      in   3      opcode; see BEHAVIOUR
//   cmd_arg     in   CNT_W  opcode argument
//   step_en     out  1      one-cycle advance strobe to generators/counter (combinational from state)
//   sel         out  SEL_W  output-mux source select (registered)
//   busy        out  1      state != IDLE
//   burst_done  out  1      one-cycle pulse coincident with final step_en of a STEP burst
//   step_count  out  CNT_W  total step_en pulses since reset, wraps 2**CNT_W-1 -> 0
//
// BEHAVIOUR
//   - Reset values: state=IDLE, div=0, sel=0, step_count=0, pre_cnt=0, burst/dwell counters=0.
//     Outputs: step_en=0, busy=0, burst_done=0, cmd_ready=1.
//   - Accept = cmd_valid && cmd_ready at a rising edge. cmd_ready=0 only in STEP; 1 otherwise.
//   - Opcodes:
//       000 PAUSE   -> IDLE.
//       001 RUN     div<=arg; -> RUN.
//       010 STEP    burst<=arg; -> STEP. arg=0: no pulse; return to IDLE next cycle.
//       011 SCAN    dwell<=max(arg,1); dwell_cnt<=0; -> SCAN.
//       100 SETDIV  div<=arg; state unchanged; pre_cnt unchanged.
//       101 SETSEL  sel<=arg[SEL_W-1:0] mod NUM_SRC; state unchanged.
//       11x         accepted, no effect.
//   - Entering RUN/STEP/SCAN, including re-entry from the same state, clears pre_cnt to 0.
//   - Prescaler, active in RUN/STEP/SCAN:
//       - step_en = (pre_cnt == div).
//       - pre_cnt <= step_en ? 0 : pre_cnt+1.
//       - First strobe is div+1 cycles after the accept edge, then one every div+1 cycles.
//       - div=0 gives a strobe every cycle.
//   - IDLE: step_en=0; pre_cnt holds.
//   - STEP: each step_en decrements burst. The strobe taken at burst==1 asserts burst_done; state -> IDLE.
//   - SCAN: each step_en increments dwell_cnt. When dwell_cnt==dwell-1 on a strobe:
//       - sel <= (sel==NUM_SRC-1) ? 0 : sel+1;
//       - dwell_cnt <= 0.
//     Outside SCAN, sel changes only via SETSEL.
//   - step_count increments on every step_en, in all states, with wrap-around.
//   - Accept coincident with step_en: the strobe still occurs (it is derived from current state).
//     The new command takes effect next cycle.
//   - SETDIV/SETSEL coincident with a SCAN sel advance: SETSEL wins for sel.
//   - reset mid-burst/mid-scan: all state returns to reset values next edge; no strobe in the
//     cycle after the reset edge.
//
// TESTING
//   1. Reset, then RUN arg=0 -> step_en high every cycle from cycle 1; step_count=5 after 5 cycles.
//   2. RUN arg=2 -> step_en at cycles 3,6,9. PAUSE at cycle 7 -> no further strobes; step_count=2.
//   3. STEP arg=3 with div=1 -> strobes at cycles 2,4,6; burst_done only at 6; cmd_ready=0 cycles 1-6.
//      busy=0 at cycle 7.
//   4. SCAN arg=2, div=0, sel=6 -> sel goes 6->7 after strobe 2, 7->0 after strobe 4 (wrap), 0->1 after 6.
//   5. STEP arg=0 -> no step_en; busy high one cycle; cmd_ready back to 1 next cycle.
//   6. Assert reset mid-STEP arg=10 after 4 strobes -> outputs equal reset values.
//      sel=0, step_count=0, next STEP accepted.

Source files
------------

// File: rtl/seq_step_sched.sv
// Step scheduler for the integer-sequence generator bank: issues the shared step_en
// advance strobe and drives the output-mux source select.
module seq_step_sched #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  output logic             step_en,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_SCAN} state_t;

  localparam logic [2:0] OP_PAUSE  = 3'b000;
  localparam logic [2:0] OP_RUN    = 3'b001;
  localparam logic [2:0] OP_STEP   = 3'b010;
  localparam logic [2:0] OP_SCAN   = 3'b011;
  localparam logic [2:0] OP_SETDIV = 3'b100;
  localparam logic [2:0] OP_SETSEL = 3'b101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic             accept;
  logic [SEL_W-1:0] sel_arg;
  logic [SEL_W-1:0] sel_wrapped;

  assign cmd_ready  = (state_q != S_STEP);
  assign busy       = (state_q != S_IDLE);
  assign sel        = sel_q;
  assign step_count = step_count_q;
  assign accept     = cmd_valid && cmd_ready;
  assign sel_arg    = cmd_arg[SEL_W-1:0];
  assign sel_wrapped = SEL_W'(32'(sel_arg) % NUM_SRC);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sel_d        = sel_q;
    step_count_d = step_count_q;
    pre_cnt_d    = pre_cnt_q;
    burst_d      = burst_q;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;

    // A zero-length burst parks in STEP for one cycle with the strobe suppressed.
    step_en    = (state_q != S_IDLE) && (pre_cnt_q == div_q) &&
                 !((state_q == S_STEP) && (burst_q == '0));
    burst_done = (state_q == S_STEP) && step_en && (burst_q == CNT_W'(1));

    if (state_q != S_IDLE) begin
      pre_cnt_d = step_en ? '0 : pre_cnt_q + CNT_W'(1);
    end
    if (step_en) begin
      step_count_d = step_count_q + CNT_W'(1);
    end

    case (state_q)
      S_STEP: begin
        if (burst_q == '0) begin
          state_d = S_IDLE;
        end else if (step_en) begin
          burst_d = burst_q - CNT_W'(1);
          if (burst_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (step_en) begin
          if (dwell_cnt_q == dwell_q - CNT_W'(1)) begin
            dwell_cnt_d = '0;
            sel_d       = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + SEL_W'(1);
          end else begin
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Commands apply after the current-state effects so a coincident SETSEL wins for sel.
    if (accept) begin
      case (cmd_op)
        OP_PAUSE: state_d = S_IDLE;
        OP_RUN: begin
          div_d     = cmd_arg;
          pre_cnt_d = '0;
          state_d   = S_RUN;
        end
        OP_STEP: begin
          burst_d   = cmd_arg;
          pre_cnt_d = '0;
          state_d   = S_STEP;
        end
        OP_SCAN: begin
          dwell_d     = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
          dwell_cnt_d = '0;
          pre_cnt_d   = '0;
          state_d     = S_SCAN;
        end
        OP_SETDIV: div_d = cmd_arg;
        OP_SETSEL: sel_d = sel_wrapped;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      sel_q        <= '0;
      step_count_q <= '0;
      pre_cnt_q    <= '0;
      burst_q      <= '0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sel_q        <= sel_d;
      step_count_q <= step_count_d;
      pre_cnt_q    <= pre_cnt_d;
      burst_q      <= burst_d;
      dwell_q      <= dwell_d;
      dwell_cnt_q  <= dwell_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_step_sched.sv
// Directed bench for seq_step_sched: a per-cycle vector table plus hand-written
// scan-wrap and mid-burst reset sequences.
module tb_seq_step_sched;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       step_en;
  logic [2:0] sel;
  logic       busy;
  logic       burst_done;
  logic [7:0] step_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  seq_step_sched #(.NUM_SRC(8), .SEL_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .step_en    (step_en),
    .sel        (sel),
    .busy       (busy),
    .burst_done (burst_done),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [7:0] arg;
    logic       e_step;
    logic       e_busy;
    logic       e_done;
    logic       e_rdy;
    logic [2:0] e_sel;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [31];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_step, input logic e_busy,
                         input logic e_done, input logic e_rdy, input logic [2:0] e_sel,
                         input logic [7:0] e_cnt);
    chk({tag, ".step_en"},    {31'd0, step_en},    {31'd0, e_step});
    chk({tag, ".busy"},       {31'd0, busy},       {31'd0, e_busy});
    chk({tag, ".burst_done"}, {31'd0, burst_done}, {31'd0, e_done});
    chk({tag, ".cmd_ready"},  {31'd0, cmd_ready},  {31'd0, e_rdy});
    chk({tag, ".sel"},        {29'd0, sel},        {29'd0, e_sel});
    chk({tag, ".step_count"}, {24'd0, step_count}, {24'd0, e_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
  endtask

  initial begin
    // Row i: inputs held during cycle i, outputs expected during cycle i (before its edge).
    //          v  op    arg     step busy done rdy sel cnt
    tbl[0]  = '{1, 3'd1, 8'd0,   0,   0,   0,   1,  0,  0};
    tbl[1]  = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  0};
    tbl[2]  = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  1};
    tbl[3]  = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  2};
    tbl[4]  = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  3};
    tbl[5]  = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  4};
    tbl[6]  = '{1, 3'd0, 8'd0,   1,   1,   0,   1,  0,  5};
    tbl[7]  = '{1, 3'd1, 8'd2,   0,   0,   0,   1,  0,  6};
    tbl[8]  = '{0, 3'd0, 8'd0,   0,   1,   0,   1,  0,  6};
    tbl[9]  = '{0, 3'd0, 8'd0,   0,   1,   0,   1,  0,  6};
    tbl[10] = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  6};
    tbl[11] = '{0, 3'd0, 8'd0,   0,   1,   0,   1,  0,  7};
    tbl[12] = '{0, 3'd0, 8'd0,   0,   1,   0,   1,  0,  7};
    tbl[13] = '{0, 3'd0, 8'd0,   1,   1,   0,   1,  0,  7};
    tbl[14] = '{1, 3'd0, 8'd0,   0,   1,   0,   1,  0,  8};
    tbl[15] = '{0, 3'd0, 8'd0,   0,   0,   0,   1,  0,  8};
    tbl[16] = '{1, 3'd4, 8'd1,   0,   0,   0,   1,  0,  8};
    tbl[17] = '{1, 3'd2, 8'd3,   0,   0,   0,   1,  0,  8};
    tbl[18] = '{0, 3'd0, 8'd0,   0,   1,   0,   0,  0,  8};
    tbl[19] = '{0, 3'd0, 8'd0,   1,   1,   0,   0,  0,  8};
    tbl[20] = '{1, 3'd0, 8'd0,   0,   1,   0,   0,  0,  9};
    tbl[21] = '{0, 3'd0, 8'd0,   1,   1,   0,   0,  0,  9};
    tbl[22] = '{0, 3'd0, 8'd0,   0,   1,   0,   0,  0, 10};
    tbl[23] = '{0, 3'd0, 8'd0,   1,   1,   1,   0,  0, 10};
    tbl[24] = '{1, 3'd4, 8'd0,   0,   0,   0,   1,  0, 11};
    tbl[25] = '{1, 3'd2, 8'd0,   0,   0,   0,   1,  0, 11};
    tbl[26] = '{0, 3'd0, 8'd0,   0,   1,   0,   0,  0, 11};
    tbl[27] = '{1, 3'd5, 8'hFD,  0,   0,   0,   1,  0, 11};
    tbl[28] = '{1, 3'd6, 8'd9,   0,   0,   0,   1,  5, 11};
    tbl[29] = '{1, 3'd5, 8'd6,   0,   0,   0,   1,  5, 11};
    tbl[30] = '{0, 3'd0, 8'd0,   0,   0,   0,   1,  6, 11};

    reset = 1'b1;
    drive(0, 3'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_out("reset", 0, 0, 0, 1, 3'd0, 8'd0);

    for (int i = 0; i < 31; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].arg);
      chk_out($sformatf("vec%0d", i), tbl[i].e_step, tbl[i].e_busy, tbl[i].e_done,
              tbl[i].e_rdy, tbl[i].e_sel, tbl[i].e_cnt);
      tick();
    end

    // SCAN dwell=2 at div=0 starting from sel=6: advances 6->7->0->1 every second strobe.
    drive(1, 3'd3, 8'd2);
    tick();
    drive(0, 3'd0, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      chk_out($sformatf("scan%0d", k), 1, 1, 0, 1, 3'((6 + (k - 1) / 2) % 8), 8'(11 + k - 1));
      tick();
    end
    drive(1, 3'd0, 8'd0);
    chk_out("scan_pause", 1, 1, 0, 1, 3'd1, 8'd17);
    tick();
    drive(0, 3'd0, 8'd0);
    chk_out("scan_idle", 0, 0, 0, 1, 3'd1, 8'd18);

    // Reset four strobes into a 10-step burst.
    drive(1, 3'd2, 8'd10);
    tick();
    drive(0, 3'd0, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      chk_out($sformatf("burst%0d", k), 1, 1, 0, 0, 3'd1, 8'(18 + k - 1));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("post_reset", 0, 0, 0, 1, 3'd0, 8'd0);
    drive(1, 3'd2, 8'd1);
    tick();
    drive(0, 3'd0, 8'd0);
    chk_out("step1", 1, 1, 1, 0, 3'd0, 8'd0);
    tick();
    chk_out("step1_done", 0, 0, 0, 1, 3'd0, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
